token_window_counter: RTL and testbench

- Serial-token consumer placed directly downstream of the token-halving stage.
- Counts '1' tokens on a 1-bit serial stream over fixed, back-to-back windows of WINDOW cycles.
- Pushes each window's count into a small output FIFO.
- The FIFO is drained by a valid/ready consumer, so a stalled reader does not lose results until the FIFO is full.

---
 rtl/token_window_counter_pkg.sv | 19 +
 rtl/token_window_counter_fifo.sv | 81 ++++++++
 rtl/token_window_counter.sv | 110 +++++++++++
 tb/tb_token_window_counter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/token_window_counter_pkg.sv
// Shared definitions for the token window counter: default geometry,
// count-width helper and the default count type.
// No ports; imported by token_cnt_fifo and token_window_counter.
package token_pkg;

  localparam int DEF_WINDOW = 8;
  localparam int DEF_DEPTH  = 2;
  localparam int DROP_W     = 8;

  // A window of N samples can hold a count of 0..N, hence N+1 values.
  function automatic int cnt_width(input int window);
    return $clog2(window + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_WINDOW);

  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/token_window_counter_fifo.sv
// Small synchronous FIFO holding finished window counts; registered head.
// Latency: a push into an empty FIFO is visible at the head one cycle later.
// Backpressure: push is refused when full unless a pop happens that cycle.
// Ports: clk_i/rst_i (sync, active-high), push_i/push_dat_i, pop_i,
//        head_dat_o/head_vld_o (registered), full_o/empty_o.
module token_cnt_fifo
  import token_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             head_vld_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] head_q, head_d;
  logic             vld_q, vld_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  // A simultaneous pop frees the slot the push lands in.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat_i;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // Head is computed from next state so the outputs are plain registers.
    vld_d  = (wr_ptr_d != rd_ptr_d);
    head_d = vld_d ? mem_d[rd_ptr_d[AW-1:0]] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      vld_q    <= vld_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_dat_o = head_q;
  assign head_vld_o = vld_q;

endmodule

// File: rtl/token_window_counter.sv
// Counts '1' tokens over back-to-back WINDOW-cycle windows into a FIFO.
// Latency: a window's count reaches the head one cycle after its last sample.
// Backpressure: results queue in the FIFO; when full, new results are dropped
//   and the sticky overflow flag is raised.
// Ports: clk, rst (sync, active-high), a (token stream),
//        cnt_data/cnt_valid/cnt_ready (result stream), overflow (sticky).
// Optional: TOKEN_WINDOW_DROP_CNT_EN adds drop_cnt[7:0], a saturating count
//   of dropped results since reset.
module token_window_counter
  import token_pkg::*;
#(
  parameter  int WINDOW = DEF_WINDOW,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int CNT_W  = cnt_width(WINDOW)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overflow
`ifdef TOKEN_WINDOW_DROP_CNT_EN
  ,
  output logic [DROP_W-1:0] drop_cnt
`endif
);

  localparam int                 POS_W    = $clog2(WINDOW);
  localparam logic [POS_W-1:0]   LAST_POS = POS_W'(WINDOW - 1);
  localparam logic [POS_W-1:0]   POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};

  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] win_sum;
  logic             overflow_q, overflow_d;
  logic             last_cyc;
  logic             fifo_full, fifo_empty;
  logic             pop_ok;
  logic             drop;

  assign last_cyc = (pos_q == LAST_POS);
  // Include this cycle's sample so the pushed value covers all WINDOW samples.
  assign win_sum  = acc_q + {{(CNT_W-1){1'b0}}, a};

  // A full FIFO only drops the result if nothing leaves it this cycle.
  assign pop_ok = cnt_ready && !fifo_empty;
  assign drop   = last_cyc && fifo_full && !pop_ok;

  always_comb begin
    pos_d      = last_cyc ? '0 : pos_q + POS_ONE;
    acc_d      = last_cyc ? '0 : win_sum;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q      <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  token_cnt_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .push_i     (last_cyc),
    .push_dat_i (win_sum),
    .pop_i      (cnt_ready),
    .head_dat_o (cnt_data),
    .head_vld_o (cnt_valid),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

`ifdef TOKEN_WINDOW_DROP_CNT_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  // Saturates at all-ones rather than wrapping back to zero.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != {DROP_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_q + DROP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  // Drops are reported only through the sticky overflow flag.
`endif

endmodule

// File: tb/tb_token_window_counter.sv
// Self-checking bench for token_window_counter (WINDOW=8, DEPTH=2).
// Window patterns are written MSB first: bit 7 is the first sample.
module tb_token_window_counter;
  import token_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a = 1'b0;
  logic       cnt_ready = 1'b0;
  cnt_t       cnt_data;
  logic       cnt_valid;
  logic       overflow;
`ifdef TOKEN_WINDOW_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  token_window_counter #(
    .WINDOW (8),
    .DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .cnt_data  (cnt_data),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready),
    .overflow  (overflow)
`ifdef TOKEN_WINDOW_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  typedef struct {
    logic [7:0] pat;
    int         exp;
  } win_vec_t;

  win_vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step(input logic a_v, input logic rdy);
    a         = a_v;
    cnt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Tokens are driven during reset to show they are ignored.
  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst = 1'b0;
    a   = 1'b0;
  endtask

  initial begin
    vecs[0] = '{pat: 8'b1100_1110, exp: 5};
    vecs[1] = '{pat: 8'b0101_0101, exp: 4};
    vecs[2] = '{pat: 8'b0000_0000, exp: 0};
    vecs[3] = '{pat: 8'b1111_1111, exp: 8};
    vecs[4] = '{pat: 8'b1000_0001, exp: 2};

    // Reset state
    do_reset();
    check("rst_valid", int'(cnt_valid), 0);
    check("rst_data", int'(cnt_data), 0);
    check("rst_overflow", int'(overflow), 0);
`ifdef TOKEN_WINDOW_DROP_CNT_EN
    check("rst_drop_cnt", int'(drop_cnt), 0);
`endif

    // Back-to-back windows, consumer always ready
    for (int i = 0; i < 5; i++) begin
      for (int b = 7; b >= 1; b--) step(vecs[i].pat[b], 1'b1);
      check($sformatf("win%0d_valid_before_end", i), int'(cnt_valid), 0);
      step(vecs[i].pat[0], 1'b1);
      check($sformatf("win%0d_valid", i), int'(cnt_valid), 1);
      check($sformatf("win%0d_data", i), int'(cnt_data), vecs[i].exp);
    end
    step(1'b0, 1'b1);
    check("stream_popped", int'(cnt_valid), 0);
    check("stream_overflow", int'(overflow), 0);

    // Stall for three windows: two stored, third dropped
    do_reset();
    for (int c = 0; c < 16; c++) step(1'b1, 1'b0);
    check("stall_full_valid", int'(cnt_valid), 1);
    check("stall_full_data", int'(cnt_data), 8);
    check("stall_no_ovf_yet", int'(overflow), 0);
    for (int c = 0; c < 8; c++) step(1'b1, 1'b0);
    check("stall_overflow", int'(overflow), 1);
    check("stall_head_held", int'(cnt_data), 8);
`ifdef TOKEN_WINDOW_DROP_CNT_EN
    check("stall_drop_cnt", int'(drop_cnt), 1);
`endif
    step(1'b0, 1'b1);
    check("stall_pop1_valid", int'(cnt_valid), 1);
    check("stall_pop1_data", int'(cnt_data), 8);
    step(1'b0, 1'b1);
    check("stall_pop2_valid", int'(cnt_valid), 0);
    check("stall_pop2_data", int'(cnt_data), 0);
    check("stall_ovf_sticky", int'(overflow), 1);

    // Full FIFO, pop on the exact cycle of the third push
    do_reset();
    check("rst_clears_ovf", int'(overflow), 0);
    for (int c = 0; c < 23; c++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("race_overflow", int'(overflow), 0);
    check("race_valid", int'(cnt_valid), 1);
    check("race_data2", int'(cnt_data), 8);
    step(1'b0, 1'b1);
    check("race_valid3", int'(cnt_valid), 1);
    check("race_data3", int'(cnt_data), 8);
    step(1'b0, 1'b1);
    check("race_empty", int'(cnt_valid), 0);
    check("race_ovf_final", int'(overflow), 0);

    // Reset mid-window discards the partial count
    do_reset();
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1);
    rst = 1'b1;
    step(1'b1, 1'b1);
    rst = 1'b0;
    check("midrst_valid", int'(cnt_valid), 0);
    for (int b = 7; b >= 1; b--) step(vecs[4].pat[b], 1'b1);
    check("midrst_no_early", int'(cnt_valid), 0);
    step(vecs[4].pat[0], 1'b1);
    check("midrst_valid_end", int'(cnt_valid), 1);
    check("midrst_data", int'(cnt_data), 2);

`ifdef TOKEN_WINDOW_DROP_CNT_EN
    // Five stalled windows: three drops
    do_reset();
    for (int c = 0; c < 40; c++) step(1'b1, 1'b0);
    check("drop5_cnt", int'(drop_cnt), 3);
    check("drop5_overflow", int'(overflow), 1);
    do_reset();
    check("drop5_rst_cnt", int'(drop_cnt), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
